// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single main-memory port between the instruction-cache miss path
// (IC) and the data-cache miss/write-back path (DC). One requester is granted
// at a time. The transaction is held until memory signals ready, and then a
// single ack pulse goes back to the winner.
//
// DC wins ties because its instruction is older in the pipeline. A streak
// counter limits how many DC grants in a row can starve a waiting IC request.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ic_req/ic_addr        IC line-fill request; held until ic_ack
//   ic_rdata/ic_ack       fill data and one-cycle completion pulse
//   dc_req/dc_we/dc_addr  DC request (we=1 write-back, we=0 fill)
//   dc_wdata              write-back line
//   dc_rdata/dc_ack       fill data and one-cycle completion pulse
//   mem_req/mem_we        memory transaction active / write transaction
//   mem_addr/mem_wdata    address and write data latched at grant
//   mem_rdata/mem_ready   memory read data, completion strobe
//   arb_busy              arbiter not idle (feeds pipeline stall logic)
//   arb_err               sticky flag for a memory timeout
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_ack,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_busy,
    output logic              arb_err
);

    localparam int STREAK_W = $clog2(STARVE_MAX + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IC = 2'd1,
        GNT_DC = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [STREAK_W-1:0] streak;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                winner_dc;
    logic                grant_dc;
    logic                grant_ic;

    // DC wins unless IC has already waited through STARVE_MAX DC grants.
    assign grant_dc = dc_req && (!ic_req || (streak != STREAK_MAX));
    assign grant_ic = ic_req && !grant_dc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. DONE always returns to IDLE, so a request that
    // drops at the end of its ack cycle is never granted a second time.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_dc) begin
                    next_state = GNT_DC;
                end else if (grant_ic) begin
                    next_state = GNT_IC;
                end
            end
            GNT_IC, GNT_DC: begin
                if (mem_ready) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: the ack is decoded from DONE together with the latched winner.
    always_comb begin
        ic_ack   = 1'b0;
        dc_ack   = 1'b0;
        arb_busy = (state != IDLE);
        if (state == DONE) begin
            ic_ack = !winner_dc;
            dc_ack = winner_dc;
        end
    end

    // Transaction datapath. The request is latched at grant, so requester
    // inputs can change freely until the next grant. The wait counter
    // saturates at TIMEOUT-1. While it sits there without ready, arb_err
    // stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
            arb_err   <= 1'b0;
            streak    <= '0;
            wait_cnt  <= '0;
            winner_dc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dc) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_addr  <= dc_addr;
                        mem_wdata <= dc_wdata;
                        wait_cnt  <= '0;
                        winner_dc <= 1'b1;
                        if (!ic_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + STREAK_W'(1);
                        end
                    end else if (grant_ic) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_addr;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                        winner_dc <= 1'b0;
                        streak    <= '0;
                    end
                end
                GNT_IC, GNT_DC: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (winner_dc) begin
                                dc_rdata <= mem_rdata;
                            end else begin
                                ic_rdata <= mem_rdata;
                            end
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        arb_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path (IC) and the data-cache miss/write-back path (DC).
- Grants one requester at a time and holds the transaction until memory signals ready, then returns one ack pulse.
- DC has priority, because its instruction is older in the pipeline. A streak counter bounds how long IC can be starved.
- arb_busy feeds the pipeline stall logic alongside the load-use stall.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width (bits) moved per transaction
- STARVE_MAX, 4, max consecutive DC grants while IC is waiting
- TIMEOUT, 64, cycles allowed for mem_ready before the error flag is set

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ic_req  in  1  IC line-fill request; held until ic_ack seen
- ic_addr  in  ADDR_W  IC line address
- ic_rdata  out  LINE_W  fill data; valid in the ic_ack cycle
- ic_ack  out  1  one-cycle completion pulse
- dc_req  in  1  DC request; held until dc_ack seen
- dc_we  in  1  1 = line write-back, 0 = line fill
- dc_addr  in  ADDR_W  DC line address
- dc_wdata  in  LINE_W  write-back data
- dc_rdata  out  LINE_W  fill data; valid in the dc_ack cycle
- dc_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory transaction active
- mem_we  out  1  write transaction
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  LINE_W  latched write data
- mem_rdata  in  LINE_W  read data; valid when mem_ready=1
- mem_ready  in  1  memory completes the current transaction this cycle
- arb_busy  out  1  state != IDLE
- arb_err  out  1  sticky timeout flag

Behaviour:
- Reset: state=IDLE; all outputs 0, including rdata registers; streak=0; wait counter=0; arb_err=0. Reset mid-transaction aborts it immediately and no ack is issued.
- States: IDLE, GNT_IC, GNT_DC, DONE.
- IDLE, arbitration:
  - dc_req only -> GNT_DC.
  - ic_req only -> GNT_IC.
  - Both requesting -> GNT_DC, unless streak == STARVE_MAX, in which case GNT_IC.
- On grant, latch the transaction:
  - mem_addr from the winner's address.
  - mem_we = dc_we for DC, 0 for IC.
  - mem_wdata = dc_wdata for DC, 0 for IC.
  - Later changes on requester inputs are ignored until the next grant.
- Streak counter:
  - DC grant while ic_req=1 -> streak+1, saturating at STARVE_MAX.
  - DC grant while ic_req=0 -> streak=0.
  - Any IC grant -> streak=0.
- GNT_IC / GNT_DC:
  - mem_req=1 (registered), first asserted in the cycle after the grant decision.
  - Wait counter increments each cycle.
  - mem_ready=1 -> capture mem_rdata into the winner's rdata register (read only; a write leaves rdata unchanged), clear mem_req, go to DONE.
  - Wait counter reaching TIMEOUT-1 without ready -> set arb_err, keep waiting. arb_err clears only on reset.
- DONE: winner's ack=1 for exactly one cycle, then IDLE.
  - Requesters drop req on the edge ending their ack cycle, so IDLE never re-grants a finished request.
  - Minimum turnaround: grant edge -> mem_req 1 cycle -> ready -> DONE -> IDLE, i.e. 3 cycles per transaction with zero memory latency.
- mem_ready outside GNT_* is ignored.
- A req rising during a transaction waits in IDLE arbitration; nothing is queued beyond the held req lines.
- arb_busy is combinational from state.

Test Plan:
- IC alone, ic_addr=0x0000_1000, memory ready 3 cycles after mem_req -> mem_addr=0x1000, mem_we=0; ic_ack pulses once with ic_rdata = memory line; arb_busy high for 5 cycles.
- DC write-back, dc_we=1, dc_addr=0x2000, dc_wdata=0xA5…A5, ready after 1 cycle -> mem_we=1, mem_wdata=0xA5…A5; dc_ack once; dc_rdata unchanged.
- ic_req and dc_req raised in the same cycle -> DC served first, then IC; ack order dc_ack, ic_ack.
- ic_req held high while DC issues 6 back-to-back requests -> grant order DC,DC,DC,DC,IC,DC,DC; streak returns to 0 after the IC grant.
- mem_ready held low for 70 cycles -> arb_err=1 at cycle 64 of waiting; transaction completes normally when ready arrives; arb_err stays 1.
- reset asserted during GNT_DC -> next cycle: IDLE, mem_req=0, no dc_ack; a fresh dc_req is then served normally.
